// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and CPU interrupt bundle for keypad_scan_ctrl.
// master: the scan controller; slave: keypad pins plus CPU side.
interface keypad_scan_ctrl_if;
  logic [3:0] rows;
  logic [2:0] cols;
  logic [3:0] key_code;
  logic       intr;
  logic       intr_ack;
  logic       overrun;

  modport master (
    input  rows, intr_ack,
    output cols, key_code, intr, overrun
  );

  modport slave (
    output rows, intr_ack,
    input  cols, key_code, intr, overrun
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 3x4 keypad scanner: one-hot column drive, synchronized row sampling,
// press/release debounce, key encoding and an acknowledged level interrupt.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 10000
) (
  input  logic               clk,
  input  logic               rst,
  keypad_scan_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       sync1;
  logic [3:0]       rs;
  logic [3:0]       row_cap;
  logic [2:0]       cols;
  logic [3:0]       key_code;
  logic             intr;
  logic             overrun;

  assign bus.cols     = cols;
  assign bus.key_code = key_code;
  assign bus.intr     = intr;
  assign bus.overrun  = overrun;

  // Map a one-hot row and one-hot column to the printed key legend.
  function automatic logic [3:0] encode(input logic [3:0] row, input logic [2:0] col);
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] code;
    r = row[3] ? 4'd3 : row[2] ? 4'd2 : row[1] ? 4'd1 : 4'd0;
    c = col[2] ? 4'd2 : col[1] ? 4'd1 : 4'd0;
    if (r == 4'd3) begin
      code = (c == 4'd0) ? 4'hE : (c == 4'd1) ? 4'h0 : 4'hF;
    end else begin
      code = 4'(r * 4'd3 + c + 4'd1);
    end
    return code;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SCAN;
      cnt      <= '0;
      sync1    <= '0;
      rs       <= '0;
      row_cap  <= '0;
      cols     <= 3'b001;
      key_code <= 4'h0;
      intr     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      sync1 <= bus.rows;
      rs    <= sync1;

      // Ack clears the interrupt; a same-cycle validation below overrides it.
      if (bus.intr_ack) begin
        intr    <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if ($onehot(rs)) begin
              row_cap <= rs;
              state   <= DEBOUNCE;
            end else begin
              cols <= {cols[1:0], cols[2]};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DEBOUNCE: begin
          if (rs != row_cap) begin
            cols  <= {cols[1:0], cols[2]};
            cnt   <= '0;
            state <= SCAN;
          end else if (cnt == DEB_LAST) begin
            key_code <= encode(row_cap, cols);
            intr     <= 1'b1;
            overrun  <= bus.intr_ack ? 1'b0 : (overrun | intr);
            cnt      <= '0;
            state    <= RELEASE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        RELEASE: begin
          // Any contact restarts the quiet-time count; one code per press.
          if (rs != 4'b0000) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cols  <= {cols[1:0], cols[2]};
            cnt   <= '0;
            state <= SCAN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a keypad pin model, a cycle-level
// behavioural reference checked every cycle, and directed scenario checks.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int P_SCAN = 0;
  localparam int P_CONF = 1;
  localparam int P_REL  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_scan_ctrl_if bus();

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Keypad pins: the pressed key's row pattern appears while its column is driven.
  logic       key_on = 1'b0;
  logic [1:0] key_col = 2'd0;
  logic [3:0] key_rows = 4'b0000;
  logic       drop = 1'b0;
  logic       ack = 1'b0;

  always_comb begin
    bus.rows = 4'b0000;
    if (key_on && bus.cols[key_col] && !drop) bus.rows = key_rows;
  end
  assign bus.intr_ack = ack;

  int checks = 0;
  int errors = 0;
  int rises  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: column index, phase, run length of the current condition.
  logic [3:0] keymap [0:3][0:2] = '{'{4'h1, 4'h2, 4'h3},
                                    '{4'h4, 4'h5, 4'h6},
                                    '{4'h7, 4'h8, 4'h9},
                                    '{4'hE, 4'h0, 4'hF}};
  int         m_col, m_phase, m_run, m_row;
  logic [3:0] m_s1, m_s2, m_pat, m_key;
  logic       m_intr, m_ovr;

  task automatic model_reset();
    m_col = 0; m_phase = P_SCAN; m_run = 0; m_row = 0;
    m_s1 = '0; m_s2 = '0; m_pat = '0;
    m_key = 4'h0; m_intr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] pins, input logic a);
    logic [3:0] seen;
    bit fire;
    seen = m_s2;
    fire = 0;
    if (m_phase == P_SCAN) begin
      m_run++;
      if (m_run == SD) begin
        m_run = 0;
        if ($countones(seen) == 1) begin
          m_pat = seen;
          m_phase = P_CONF;
          for (int i = 0; i < 4; i++) if (seen[i]) m_row = i;
        end else begin
          m_col = (m_col + 1) % 3;
        end
      end
    end else if (m_phase == P_CONF) begin
      if (seen != m_pat) begin
        m_col = (m_col + 1) % 3; m_run = 0; m_phase = P_SCAN;
      end else begin
        m_run++;
        if (m_run == DB) begin fire = 1; m_run = 0; m_phase = P_REL; end
      end
    end else begin
      if (seen == 4'b0000) begin
        m_run++;
        if (m_run == DB) begin m_col = (m_col + 1) % 3; m_run = 0; m_phase = P_SCAN; end
      end else begin
        m_run = 0;
      end
    end
    if (fire) begin
      m_ovr  = a ? 1'b0 : (m_ovr | m_intr);
      m_intr = 1'b1;
      m_key  = keymap[m_row][m_col];
    end else if (a) begin
      m_intr = 1'b0; m_ovr = 1'b0;
    end
    m_s2 = m_s1;
    m_s1 = pins;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step(bus.rows, bus.intr_ack);
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  initial begin
    logic [2:0] exp_cols;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_cols = 3'(1 << m_col);
        chk("cols", 32'(bus.cols), 32'(exp_cols));
        chk("key_code", 32'(bus.key_code), 32'(m_key));
        chk("intr", 32'(bus.intr), 32'(m_intr));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
      end
    end
  end

  // Interrupt rising-edge counter.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.intr && !prev) rises++;
      prev = bus.intr;
    end
  end

  task automatic press(input logic [3:0] r, input logic [1:0] c);
    key_rows = r; key_col = c; key_on = 1'b1;
  endtask

  task automatic wait_intr(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.intr && n < budget) begin @(negedge clk); n++; end
    if (!bus.intr) chk(name, 32'(bus.intr), 32'd1);
  endtask

  task automatic wait_key(input string name, input logic [3:0] code, input int budget);
    int n;
    n = 0;
    while (bus.key_code !== code && n < budget) begin @(negedge clk); n++; end
    if (bus.key_code !== code) chk(name, 32'(bus.key_code), 32'(code));
  endtask

  task automatic wait_phase(input string name, input int ph, input int run, input int budget);
    int n;
    n = 0;
    while (!(m_phase == ph && (run < 0 || m_run == run)) && n < budget) begin
      @(negedge clk); n++;
    end
    if (!(m_phase == ph && (run < 0 || m_run == run))) chk(name, 32'(m_phase), 32'(ph));
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [2:0] rot [0:2];
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;

    // Power-on reset values.
    cycles(2);
    chk("por_cols", 32'(bus.cols), 32'h1);
    chk("por_key", 32'(bus.key_code), 32'h0);
    chk("por_intr", 32'(bus.intr), 32'h0);
    chk("por_ovr", 32'(bus.overrun), 32'h0);
    rst = 1'b0;

    // Clean press of "5", held 40 cycles.
    rises = 0;
    press(4'b0010, 2'd1);
    cycles(40);
    key_on = 1'b0;
    chk("five_intr", 32'(bus.intr), 32'h1);
    chk("five_key", 32'(bus.key_code), 32'h5);
    chk("five_rises", 32'(rises), 32'h1);
    cycles(9);
    chk("five_still_release", 32'(m_phase), 32'(P_REL));
    chk("five_col_frozen", 32'(bus.cols), 32'h2);
    cycles(1);
    chk("five_resume", 32'(m_phase), 32'(P_SCAN));
    chk("five_col_next", 32'(bus.cols), 32'h4);
    ack_pulse();
    chk("five_ack_intr", 32'(bus.intr), 32'h0);
    chk("five_ack_key", 32'(bus.key_code), 32'h5);

    // Mid-cycle reset during a held press, then rotation from column 0.
    press(4'b0001, 2'd1);
    wait_intr("two_timeout", 60);
    cycles(3);
    #2 rst = 1'b1;
    #1;
    chk("rst_cols", 32'(bus.cols), 32'h1);
    chk("rst_key", 32'(bus.key_code), 32'h0);
    chk("rst_intr", 32'(bus.intr), 32'h0);
    chk("rst_ovr", 32'(bus.overrun), 32'h0);
    key_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      chk("rotate", 32'(bus.cols), 32'(rot[(j / 4) % 3]));
    end

    // Bounce on "#": one-cycle contact drop inside the debounce window.
    rises = 0;
    press(4'b1000, 2'd2);
    wait_phase("hash_deb_timeout", P_CONF, 4, 40);
    drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    cycles(3);
    chk("bounce_scan", 32'(m_phase), 32'(P_SCAN));
    chk("bounce_no_intr", 32'(bus.intr), 32'h0);
    wait_intr("hash_timeout", 60);
    chk("hash_key", 32'(bus.key_code), 32'hF);
    chk("hash_rises", 32'(rises), 32'h1);
    key_on = 1'b0;
    wait_phase("hash_rel_timeout", P_SCAN, -1, 30);
    ack_pulse();

    // Overrun: "1" left unacknowledged, then "9".
    press(4'b0001, 2'd0);
    wait_intr("one_timeout", 60);
    chk("one_key", 32'(bus.key_code), 32'h1);
    key_on = 1'b0;
    wait_phase("one_rel_timeout", P_SCAN, -1, 30);
    press(4'b0100, 2'd2);
    wait_key("nine_timeout", 4'h9, 60);
    chk("ovr_intr", 32'(bus.intr), 32'h1);
    chk("ovr_set", 32'(bus.overrun), 32'h1);
    key_on = 1'b0;
    wait_phase("nine_rel_timeout", P_SCAN, -1, 30);
    ack_pulse();
    chk("ovr_ack_intr", 32'(bus.intr), 32'h0);
    chk("ovr_ack_ovr", 32'(bus.overrun), 32'h0);
    chk("ovr_ack_key", 32'(bus.key_code), 32'h9);

    // Ghosting: two rows on column 0 never qualify.
    rises = 0;
    press(4'b0011, 2'd0);
    cycles(30);
    key_on = 1'b0;
    chk("ghost_rises", 32'(rises), 32'h0);
    chk("ghost_intr", 32'(bus.intr), 32'h0);
    chk("ghost_scan", 32'(m_phase), 32'(P_SCAN));

    // Ack collides with validation of "0" while "*" is pending.
    press(4'b1000, 2'd0);
    wait_intr("star_timeout", 60);
    chk("star_key", 32'(bus.key_code), 32'hE);
    key_on = 1'b0;
    wait_phase("star_rel_timeout", P_SCAN, -1, 30);
    press(4'b1000, 2'd1);
    wait_phase("zero_deb_timeout", P_CONF, DB - 1, 60);
    ack_pulse();
    chk("coll_intr", 32'(bus.intr), 32'h1);
    chk("coll_key", 32'(bus.key_code), 32'h0);
    chk("coll_ovr", 32'(bus.overrun), 32'h0);
    key_on = 1'b0;
    wait_phase("zero_rel_timeout", P_SCAN, -1, 30);
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
